preg_port_arbiter: RTL and testbench

Shares the single read/write port 0 of the 64-entry pointer register file (12-bit label ID plus 16-bit offset per entry) among one read client and two write clients. On any cycle the file either writes `pw` or reads `p0`, never both, so this block picks at most one access per cycle with round-robin fairness and drives the file's `p0`/`pw`/`we`/write-data inputs. A write to the PC pointer (entry 63) is followed by a one-cycle issue bubble and a flush pulse to the fetch logic. Read port 1 is not arbitrated and stays wired directly to the decoder.

---
 rtl/preg_port_arbiter_if.sv | 48 ++++
 rtl/preg_port_arbiter.sv | 81 ++++++++
 tb/tb_preg_port_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/preg_port_arbiter_if.sv
// Port-0 access bundle between the pointer register file arbiter and its clients.
// Carries the read/write client handshakes and the file-side port 0 drive signals.
interface preg_port_arbiter_if #(
  parameter int unsigned PTR_W = 6
);
  localparam int unsigned LBID_W = 12;
  localparam int unsigned OFS_W  = 16;

  logic              rd_req;
  logic [PTR_W-1:0]  rd_ptr;
  logic              rd_gnt;
  logic              rd_valid;

  logic              wa_req;
  logic [PTR_W-1:0]  wa_ptr;
  logic [LBID_W-1:0] wa_lbid;
  logic [OFS_W-1:0]  wa_ofs;
  logic              wa_gnt;

  logic              wb_req;
  logic [PTR_W-1:0]  wb_ptr;
  logic [LBID_W-1:0] wb_lbid;
  logic [OFS_W-1:0]  wb_ofs;
  logic              wb_gnt;

  logic [PTR_W-1:0]  preg_p0;
  logic [PTR_W-1:0]  preg_pw;
  logic [LBID_W-1:0] preg_lbidw;
  logic [OFS_W-1:0]  preg_ofsw;
  logic              preg_we;
  logic              pc_flush;

  modport master (
    output rd_req, rd_ptr,
    output wa_req, wa_ptr, wa_lbid, wa_ofs,
    output wb_req, wb_ptr, wb_lbid, wb_ofs,
    input  rd_gnt, rd_valid, wa_gnt, wb_gnt,
    input  preg_p0, preg_pw, preg_lbidw, preg_ofsw, preg_we, pc_flush
  );

  modport slave (
    input  rd_req, rd_ptr,
    input  wa_req, wa_ptr, wa_lbid, wa_ofs,
    input  wb_req, wb_ptr, wb_lbid, wb_ofs,
    output rd_gnt, rd_valid, wa_gnt, wb_gnt,
    output preg_p0, preg_pw, preg_lbidw, preg_ofsw, preg_we, pc_flush
  );
endinterface

// File: rtl/preg_port_arbiter.sv
// Round-robin arbiter for port 0 of the pointer register file (one read, two writers).
// A granted write to the PC pointer inserts a one-cycle issue bubble and pulses pc_flush.
module preg_port_arbiter #(
  parameter int unsigned      PTR_W  = 6,
  parameter logic [PTR_W-1:0] PC_PTR = PTR_W'(6'h3f)
) (
  input logic                clk,
  input logic                rst_n,
  preg_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    SRC_RD = 2'd0,
    SRC_WA = 2'd1,
    SRC_WB = 2'd2
  } src_e;

  src_e last_q, last_d;
  logic block_q, block_d;
  logic rd_valid_q, rd_valid_d;
  logic rd_gnt_c, wa_gnt_c, wb_gnt_c;

  // Priority starts at the client after the most recent grant; nothing issues in reset or a bubble.
  always_comb begin
    rd_gnt_c = 1'b0;
    wa_gnt_c = 1'b0;
    wb_gnt_c = 1'b0;
    if (rst_n && !block_q) begin
      case (last_q)
        SRC_RD: begin
          if (bus.wa_req)      wa_gnt_c = 1'b1;
          else if (bus.wb_req) wb_gnt_c = 1'b1;
          else if (bus.rd_req) rd_gnt_c = 1'b1;
        end
        SRC_WA: begin
          if (bus.wb_req)      wb_gnt_c = 1'b1;
          else if (bus.rd_req) rd_gnt_c = 1'b1;
          else if (bus.wa_req) wa_gnt_c = 1'b1;
        end
        default: begin
          if (bus.rd_req)      rd_gnt_c = 1'b1;
          else if (bus.wa_req) wa_gnt_c = 1'b1;
          else if (bus.wb_req) wb_gnt_c = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    last_d     = last_q;
    rd_valid_d = rd_gnt_c;
    block_d    = (wa_gnt_c && (bus.wa_ptr == PC_PTR)) ||
                 (wb_gnt_c && (bus.wb_ptr == PC_PTR));
    if (rd_gnt_c)      last_d = SRC_RD;
    else if (wa_gnt_c) last_d = SRC_WA;
    else if (wb_gnt_c) last_d = SRC_WB;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q     <= SRC_WB;
      block_q    <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      block_q    <= block_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Idle write mux defaults to client A's payload; the file ignores it without preg_we.
  assign bus.rd_gnt     = rd_gnt_c;
  assign bus.wa_gnt     = wa_gnt_c;
  assign bus.wb_gnt     = wb_gnt_c;
  assign bus.preg_we    = wa_gnt_c | wb_gnt_c;
  assign bus.preg_pw    = wb_gnt_c ? bus.wb_ptr  : bus.wa_ptr;
  assign bus.preg_lbidw = wb_gnt_c ? bus.wb_lbid : bus.wa_lbid;
  assign bus.preg_ofsw  = wb_gnt_c ? bus.wb_ofs  : bus.wa_ofs;
  assign bus.preg_p0    = bus.rd_ptr;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.pc_flush   = block_q;
endmodule

// File: tb/tb_preg_port_arbiter.sv
// Bench for preg_port_arbiter: directed scenarios plus randomized clients, checked
// every cycle against a behavioural arbiter model and a model of the register file.
module tb_preg_port_arbiter;
  localparam int unsigned      PTR_W = 6;
  localparam logic [PTR_W-1:0] PC    = 6'h3f;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  preg_port_arbiter_if #(.PTR_W(PTR_W)) bus ();
  preg_port_arbiter #(.PTR_W(PTR_W), .PC_PTR(PC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // client index: 0 = RD, 1 = WA, 2 = WB
  logic [2:0]       req;
  logic [PTR_W-1:0] ptr  [3];
  logic [11:0]      lbid [3];
  logic [15:0]      ofs  [3];

  assign bus.rd_req  = req[0];
  assign bus.rd_ptr  = ptr[0];
  assign bus.wa_req  = req[1];
  assign bus.wa_ptr  = ptr[1];
  assign bus.wa_lbid = lbid[1];
  assign bus.wa_ofs  = ofs[1];
  assign bus.wb_req  = req[2];
  assign bus.wb_ptr  = ptr[2];
  assign bus.wb_lbid = lbid[2];
  assign bus.wb_ofs  = ofs[2];

  // Register file port 0: write when we, otherwise registered read of p0.
  logic [27:0] f_mem [64];
  logic [27:0] f_rd;
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) f_mem[i] <= '0;
      f_rd <= '0;
    end else if (bus.preg_we) begin
      f_mem[bus.preg_pw] <= {bus.preg_lbidw, bus.preg_ofsw};
    end else begin
      f_rd <= f_mem[bus.preg_p0];
    end
  end

  // Reference model state
  int          m_last;
  bit          m_block, m_valid;
  logic [27:0] m_cap;
  logic [27:0] ref_mem [64];
  logic [2:0]  e_g, last_eff;
  bit          hold, rst_edge;
  int          n_chk, n_fail;

  bit          lit_g_en, lit_f_en, lit_d_en;
  logic [2:0]  lit_g;
  logic        lit_f;
  logic [27:0] lit_d;
  logic [2:0]  fseq [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    logic [2:0] eff;
    int c;
    int w;
    @(negedge clk);
    e_g = '0;
    if (rst_n && !m_block) begin
      for (int k = 1; k <= 3; k++) begin
        c = (m_last + k) % 3;
        if (req[c] && (e_g == 3'b000)) e_g[c] = 1'b1;
      end
    end
    chk("grants", {29'd0, bus.wb_gnt, bus.wa_gnt, bus.rd_gnt}, {29'd0, e_g});
    chk("preg_we", 32'(bus.preg_we), 32'(e_g[1] | e_g[2]));
    chk("pc_flush", 32'(bus.pc_flush), 32'(m_block));
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_valid));
    chk("preg_p0", 32'(bus.preg_p0), 32'(ptr[0]));
    if (e_g[1] | e_g[2]) begin
      w = e_g[2] ? 2 : 1;
      chk("preg_pw", 32'(bus.preg_pw), 32'(ptr[w]));
      chk("wr_data", 32'({bus.preg_lbidw, bus.preg_ofsw}), 32'({lbid[w], ofs[w]}));
    end
    if (m_valid) chk("rd_data", 32'(f_rd), 32'(m_cap));
    if (lit_g_en) chk("lit_grants", {29'd0, bus.wb_gnt, bus.wa_gnt, bus.rd_gnt}, {29'd0, lit_g});
    if (lit_f_en) chk("lit_pc_flush", 32'(bus.pc_flush), 32'(lit_f));
    if (lit_d_en) chk("lit_rd_data", 32'(f_rd), 32'(lit_d));
    if (rst_edge) begin
      rst_n    = 1'b0;
      rst_edge = 1'b0;
    end
    @(posedge clk);
    #1;
    eff = rst_n ? e_g : 3'b000;
    if (!rst_n) begin
      m_last  = 2;
      m_block = 1'b0;
      m_valid = 1'b0;
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    end else begin
      m_valid = eff[0];
      if (eff[0]) m_cap = ref_mem[ptr[0]];
      m_block = 1'b0;
      for (int i = 1; i < 3; i++) begin
        if (eff[i]) begin
          ref_mem[ptr[i]] = {lbid[i], ofs[i]};
          m_block = (ptr[i] == PC);
        end
      end
      for (int i = 0; i < 3; i++) if (eff[i]) m_last = i;
    end
    for (int i = 0; i < 3; i++) if (eff[i] && !hold) req[i] = 1'b0;
    last_eff = eff;
  endtask

  task automatic run_until(input int cl, input int max);
    for (int n = 0; n < max; n++) begin
      cycle();
      if (last_eff[cl]) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL timeout: client %0d not granted within %0d cycles", cl, max);
  endtask

  task automatic lit_cycle(input logic [2:0] g);
    lit_g_en = 1'b1;
    lit_g    = g;
    cycle();
    lit_g_en = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    lit_g_en = 0; lit_f_en = 0; lit_d_en = 0; lit_g = '0; lit_f = 0; lit_d = '0;
    rst_edge = 0; last_eff = '0; e_g = '0; m_cap = '0;
    m_last = 2; m_block = 0; m_valid = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    fseq[0] = 3'b001; fseq[1] = 3'b010; fseq[2] = 3'b100;
    fseq[3] = 3'b001; fseq[4] = 3'b010; fseq[5] = 3'b100;

    // Reset with every client requesting
    rst_n = 1'b0; hold = 1'b1; req = 3'b111;
    ptr[0] = 6'd5;
    ptr[1] = 6'd2; lbid[1] = 12'h00A; ofs[1] = 16'h1234;
    ptr[2] = 6'd3; lbid[2] = 12'h0BB; ofs[2] = 16'h5678;
    @(posedge clk);
    #1;
    lit_f_en = 1'b1; lit_f = 1'b0;
    repeat (3) lit_cycle(3'b000);
    lit_f_en = 1'b0;

    // Fairness: RD first, then strict rotation
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) lit_cycle(fseq[i]);
    hold = 1'b0;
    repeat (4) cycle();

    // Read-after-write on pointer 7
    ptr[1] = 6'd7; lbid[1] = 12'h123; ofs[1] = 16'hBEEF; req[1] = 1'b1;
    run_until(1, 4);
    ptr[0] = 6'd7; req[0] = 1'b1;
    run_until(0, 4);
    lit_d_en = 1'b1; lit_d = 28'h123BEEF;
    cycle();
    lit_d_en = 1'b0;

    // PC write by WB while RD and WA wait
    ptr[1] = 6'd10; lbid[1] = 12'h0C0; ofs[1] = 16'h0C0C; req[1] = 1'b1;
    run_until(1, 4);
    ptr[0] = 6'd1; ptr[1] = 6'd4; ptr[2] = PC; lbid[2] = 12'h3AB; ofs[2] = 16'h4000;
    req = 3'b111;
    lit_cycle(3'b100);
    lit_f_en = 1'b1; lit_f = 1'b1;
    lit_cycle(3'b000);
    lit_f_en = 1'b0;
    lit_cycle(3'b001);
    repeat (3) cycle();

    // Two writers on pointer 9: later grant wins
    ptr[0] = 6'd0; req[0] = 1'b1;
    run_until(0, 4);
    ptr[1] = 6'd9; lbid[1] = 12'h111; ofs[1] = 16'h0001;
    ptr[2] = 6'd9; lbid[2] = 12'h222; ofs[2] = 16'h0002;
    req[1] = 1'b1; req[2] = 1'b1;
    lit_cycle(3'b010);
    lit_cycle(3'b100);
    ptr[0] = 6'd9; req[0] = 1'b1;
    run_until(0, 4);
    lit_d_en = 1'b1; lit_d = 28'h2220002;
    cycle();
    lit_d_en = 1'b0;

    // Reset at the edge ending a PC-write grant
    ptr[2] = PC; lbid[2] = 12'h555; ofs[2] = 16'h6666; req[2] = 1'b1;
    rst_edge = 1'b1;
    lit_cycle(3'b100);
    lit_f_en = 1'b1; lit_f = 1'b0;
    repeat (2) lit_cycle(3'b000);
    lit_f_en = 1'b0;
    rst_n = 1'b1;
    lit_cycle(3'b100);
    repeat (2) cycle();

    // Randomized clients with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if (rst_n && ($urandom_range(0, 199) == 0)) begin
        if ($urandom_range(0, 1) == 1) rst_edge = 1'b1;
        else rst_n = 1'b0;
      end else if (!rst_n && ($urandom_range(0, 1) == 1)) begin
        rst_n = 1'b1;
      end
      for (int c = 0; c < 3; c++) begin
        if (!req[c]) begin
          ptr[c]  = ($urandom_range(0, 7) == 0) ? PC : PTR_W'($urandom_range(0, 7));
          lbid[c] = 12'($urandom);
          ofs[c]  = 16'($urandom);
          if ($urandom_range(0, 1) == 1) req[c] = 1'b1;
        end
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
